// File: rtl/can_stuff_checker.sv
// ============================================================================
// Module   : can_stuff_checker
// Brief    : CAN receive-path bit-stuffing checker and destuffer.
//            Optional macro CAN_STUFF_ERR_CNT_EN enables the saturating
//            stuff-error counter; otherwise o_err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_stuff_checker #(
    parameter int STUFF_LEN = 5,
    parameter int CNT_W     = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Sample,
    input  logic             i_Data,
    input  logic             i_Enable,
    input  logic             i_Clear,
    output logic             o_data,
    output logic             o_data_valid,
    output logic             o_stuff_bit,
    output logic             o_stuff_error,
    output logic             o_stuff_monitor,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [3:0] C_RUN_MAX = 4'(STUFF_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_EXPECT = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] run_q, run_d;
    logic       data_q, data_d;
    logic       valid_q, valid_d;
    logic       stuff_q, stuff_d;
    logic       error_q, error_d;
    logic       mon_q, mon_d;
    logic [3:0] w_run_next;

    assign w_run_next = (i_Data == last_q) ? (run_q + 4'd1) : 4'd1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        run_d   = run_q;
        data_d  = data_q;
        valid_d = 1'b0;
        stuff_d = 1'b0;
        error_d = 1'b0;

        if (!i_Enable) begin
            // Leaving the stuffed region: samples on this cycle are ignored.
            state_d = S_IDLE;
            run_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    run_d = 4'd0;
                    if (i_Sample) begin
                        last_d  = i_Data;
                        run_d   = 4'd1;
                        data_d  = i_Data;
                        valid_d = 1'b1;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (i_Sample) begin
                        last_d  = i_Data;
                        run_d   = w_run_next;
                        data_d  = i_Data;
                        valid_d = 1'b1;
                        if (w_run_next == C_RUN_MAX) begin
                            state_d = S_EXPECT;
                        end
                    end
                end
                S_EXPECT: begin
                    if (i_Sample) begin
                        if (i_Data != last_q) begin
                            // The stuff bit is dropped but opens the next run.
                            stuff_d = 1'b1;
                            last_d  = i_Data;
                            run_d   = 4'd1;
                            state_d = S_COUNT;
                        end else begin
                            error_d = 1'b1;
                            state_d = S_ERROR;
                        end
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    // A new error outranks a simultaneous clear.
    always_comb begin
        mon_d = mon_q;
        if (i_Clear) begin
            mon_d = 1'b0;
        end
        if (error_d) begin
            mon_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            run_q   <= 4'd0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            stuff_q <= 1'b0;
            error_q <= 1'b0;
            mon_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            run_q   <= run_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            stuff_q <= stuff_d;
            error_q <= error_d;
            mon_q   <= mon_d;
        end
    end

`ifdef CAN_STUFF_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_Clear) begin
            err_cnt_d = '0;
        end
        if (error_d && (err_cnt_d != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_count = err_cnt_q;
`else
    assign o_err_count = '0;
`endif

    assign o_data          = data_q;
    assign o_data_valid    = valid_q;
    assign o_stuff_bit     = stuff_q;
    assign o_stuff_error   = error_q;
    assign o_stuff_monitor = mon_q;

endmodule

`default_nettype wire

// File: doc/can_stuff_checker.md
# can_stuff_checker

Parametrised CAN bit-stuffing checker and destuffer for the receive path. At each bit sample point it tracks runs of equal bits, flags the stuff bit inserted after STUFF_LEN equal bits, forwards only destuffed data bits, and detects stuff-rule violations. It sits between the bit-timing sampler and the frame receiver. It supersedes the single-compare stuff monitor with run-length tracking, destuffing, a sticky error flag and an error count.

## Interface
- STUFF_LEN, 5: equal-bit run length after which a complementary stuff bit is mandatory; legal range 2..15.
- CNT_W, 8: width of the stuff-error counter.
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Sample  in  1  one-cycle strobe; i_Data is the sampled bus bit on this cycle.
- i_Data  in  1  sampled bus level (0 = dominant).
- i_Enable  in  1  high while inside the stuffed region (SOF through CRC sequence).
- i_Clear  in  1  one-cycle pulse; clears o_stuff_monitor and o_err_count.
- o_data  out  1  destuffed data bit.
- o_data_valid  out  1  one-cycle pulse qualifying o_data.
- o_stuff_bit  out  1  one-cycle pulse: sampled bit was a valid stuff bit, dropped.
- o_stuff_error  out  1  one-cycle pulse on stuff violation.
- o_stuff_monitor  out  1  sticky stuff-error flag.
- o_err_count  out  CNT_W  saturating stuff-error count.

## Operation
- Internal state: last bit (1 b), run count (4 b, range 0..STUFF_LEN), FSM {IDLE, COUNT, EXPECT, ERROR}.
- IDLE: run count = 0. On i_Sample with i_Enable = 1: last = i_Data, count = 1, emit data bit, go COUNT.
- COUNT, on i_Sample: if i_Data == last, count + 1, else last = i_Data, count = 1. Emit data bit. When the new count equals STUFF_LEN, go EXPECT.
- EXPECT, on i_Sample: if i_Data != last, pulse o_stuff_bit with no data_valid, set last = i_Data, count = 1 (the stuff bit starts the next run), go COUNT. If i_Data == last, pulse o_stuff_error, set o_stuff_monitor, increment o_err_count, go ERROR.
- ERROR: ignore samples and emit nothing until i_Enable = 0.
- i_Enable = 0 in any state: go IDLE next cycle and clear the count. A sample on that cycle is ignored. Sticky flag and counter are kept.
- o_err_count saturates at 2^CNT_W − 1.
- Simultaneous i_Clear and new error: the error takes priority. Monitor ends at 1 and the count at 1.
- i_Clear never changes FSM state.

## Timing
- All outputs are registered. Pulses assert exactly one cycle after the i_Sample cycle and last one cycle.
- o_data holds its value until the next valid bit.
- Reset values: o_data 0, o_data_valid 0, o_stuff_bit 0, o_stuff_error 0, o_stuff_monitor 0, o_err_count 0, FSM IDLE.
- i_Reset asserted mid-frame returns everything to reset values in the next cycle, including the sticky flag and counter.
- Back-to-back i_Sample on consecutive cycles must be supported with no lost bits.
- i_Sample with i_Enable = 0: no outputs pulse.

## Configuration
- CAN_STUFF_ERR_CNT_EN defined: the saturating o_err_count counter is implemented as described.
- CAN_STUFF_ERR_CNT_EN not defined: the counter logic is removed and o_err_count is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- STUFF_LEN = 5, enable, bits 0,0,0,0,0,1,0,1: five data_valid with o_data = 0, then o_stuff_bit once with no data_valid, then data 0,1. No error.
- Bits 1,1,1,1,1,1: five data_valid pulses, then o_stuff_error pulse. o_stuff_monitor = 1, o_err_count = 1, and further samples produce nothing until i_Enable falls.
- Stuff bit starts a run: 0×5, stuff 1, then 1,1,1,1: EXPECT is reached after 4 data 1s. A following 1 raises an error, a following 0 gives o_stuff_bit.
- CNT_W = 2, four error frames: o_err_count reads 1, 2, 3, 3. Then i_Clear gives count 0 and monitor 0. i_Clear on the error cycle gives count 1.
- i_Reset asserted in EXPECT: all outputs are 0 next cycle. The next enabled sample starts a fresh run with count 1.
- With the macro undefined, repeat the violation scenario: o_stuff_error and o_stuff_monitor still assert, and o_err_count stays 0.
